// File: rtl/decode_stage.sv
// RV32I decode stage: 2R/1W register file, load-use stall, flush, valid/ready output register.
// Optional DECODE_WB_BYPASS_EN: same-cycle writeback data is forwarded to the read ports.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_is_load,
  output logic            out_reg_write,
  output logic            out_illegal
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011,
    OPC_FENCE  = 7'b0001111
  } opcode_e;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            uses_rs1, uses_rs2, legal, writes_rd;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;
  logic            hazard, accept;

  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  always_comb begin
    imm       = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    legal     = 1'b1;
    writes_rd = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        imm       = {in_instr[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        imm       = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        imm       = {{20{in_instr[31]}}, in_instr[31:20]};
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_STORE: begin
        imm      = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_SYSTEM, OPC_FENCE: imm = {{20{in_instr[31]}}, in_instr[31:20]};
      default: legal = 1'b0;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_data = (rs1 == '0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];
`else
  assign rs1_data = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`endif

  // Load-use: the load in the output register cannot yet supply its result.
  assign hazard = out_valid && out_is_load && (out_rd != '0) && in_valid &&
                  ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));
  assign in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7b5  <= 1'b0;
      out_is_load   <= 1'b0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else begin
      if (wb_we && wb_rd != '0) regs[wb_rd] <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_rs1_data  <= rs1_data;
        out_rs2_data  <= rs2_data;
        out_imm       <= imm;
        out_rd        <= rd;
        out_rs1       <= rs1;
        out_rs2       <= rs2;
        out_opcode    <= opc;
        out_funct3    <= in_instr[14:12];
        out_funct7b5  <= in_instr[30];
        out_is_load   <= (opc == OPC_LOAD);
        out_reg_write <= legal && writes_rd && (rd != '0);
        out_illegal   <= !legal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against a behavioural RV32I decode model.
module tb_decode_stage;

  logic        clk, rst_n, in_valid, in_ready, flush, wb_we, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_is_load, out_reg_write, out_illegal;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_is_load(out_is_load), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5, is_load, reg_write, illegal;
  } bundle_t;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic        m_valid;
  bundle_t     m_out;
  logic [31:0] mregs [32];
  logic        after_rst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && wb_rd == r) return wb_data;
`endif
    return mregs[r];
  endfunction

  // Does this instruction's format name register r as a source?
  function automatic logic ref_reads(input logic [31:0] instr, input logic [4:0] r);
    int op;
    logic a, b;
    op = int'(instr[6:0]);
    a  = (op == 'h67 || op == 'h63 || op == 'h03 || op == 'h23 || op == 'h13 || op == 'h33);
    b  = (op == 'h63 || op == 'h23 || op == 'h33);
    return (a && instr[19:15] == r) || (b && instr[24:20] == r);
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] pc, input logic [31:0] instr);
    bundle_t b;
    int s, op;
    logic legal, writes;
    s      = $signed(instr);
    op     = int'(instr[6:0]);
    legal  = 1'b1;
    writes = 1'b0;
    b.imm  = 32'd0;
    case (op)
      'h37, 'h17: begin b.imm = instr & 32'hFFFF_F000; writes = 1'b1; end
      'h6F: begin
        b.imm = ((s >>> 31) * (1 << 20)) + int'(instr[19:12]) * (1 << 12)
              + int'(instr[20]) * (1 << 11) + int'(instr[30:21]) * 2;
        writes = 1'b1;
      end
      'h67, 'h03, 'h13: begin b.imm = s >>> 20; writes = 1'b1; end
      'h63: b.imm = ((s >>> 31) * (1 << 12)) + int'(instr[7]) * (1 << 11)
                  + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2;
      'h23: b.imm = ((s >>> 25) * 32) + int'(instr[11:7]);
      'h33: writes = 1'b1;
      'h73, 'h0F: b.imm = s >>> 20;
      default: legal = 1'b0;
    endcase
    b.pc        = pc;
    b.rd        = instr[11:7];
    b.rs1       = instr[19:15];
    b.rs2       = instr[24:20];
    b.rs1_data  = ref_read(b.rs1);
    b.rs2_data  = ref_read(b.rs2);
    b.opcode    = instr[6:0];
    b.funct3    = instr[14:12];
    b.f7b5      = instr[30];
    b.is_load   = (op == 'h03);
    b.reg_write = legal && writes && b.rd != 0;
    b.illegal   = !legal;
    return b;
  endfunction

  task automatic tick();
    bundle_t nb;
    logic hz, er;
    logic [28:0] act_ctl;
    #1;
    hz = m_valid && m_out.is_load && m_out.rd != 0 && in_valid && ref_reads(in_instr, m_out.rd);
    er = rst_n && (!m_valid || out_ready) && !hz && !flush;
    check("in_ready", in_ready, er);
    nb = ref_decode(in_pc, in_instr);
    @(posedge clk);
    if (!rst_n) begin
      m_valid   = 1'b0;
      m_out     = '0;
      after_rst = 1'b1;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else begin
      after_rst = 1'b0;
      if (flush) m_valid = 1'b0;
      else if (in_valid && er) begin m_valid = 1'b1; m_out = nb; end
      else if (out_ready) m_valid = 1'b0;
      if (wb_we && wb_rd != 0) mregs[wb_rd] = wb_data;
    end
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid || after_rst) begin
      act_ctl = {out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7b5,
                 out_is_load, out_reg_write, out_illegal};
      check("out_pc", out_pc, m_out.pc);
      check("out_rs1_data", out_rs1_data, m_out.rs1_data);
      check("out_rs2_data", out_rs2_data, m_out.rs2_data);
      check("out_imm", out_imm, m_out.imm);
      check("out_ctl", act_ctl, m_out[28:0]);
    end
    @(negedge clk);
  endtask

  task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h7F};
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(11)];
    w[11:7]  = 5'($urandom_range(5));
    w[19:15] = 5'($urandom_range(5));
    w[24:20] = 5'($urandom_range(5));
    return w;
  endfunction

  initial begin
    logic [31:0] same_cycle_exp;
    m_valid   = 1'b0;
    m_out     = '0;
    after_rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    present(1'b1, 32'h0, 32'h0050_0093);
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_imm", out_imm, 32'd0);

    // addi x1,x0,5
    rst_n = 1'b1;
    present(1'b1, 32'h0, 32'h0050_0093);
    tick();
    check("addi_valid", out_valid, 1'b1);
    check("addi_rd", out_rd, 5'd1);
    check("addi_imm", out_imm, 32'd5);
    check("addi_rw", out_reg_write, 1'b1);

    // writeback x1 then add x3,x1,x1
    present(1'b0, 32'h4, 32'h0);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_we = 1'b0;
    present(1'b1, 32'h8, 32'h0010_81B3);
    tick();
    check("add_rs1d", out_rs1_data, 32'hDEAD_BEEF);
    check("add_rs2d", out_rs2_data, 32'hDEAD_BEEF);

    // same-cycle write of x2 while add x4,x2,x2 decodes
`ifdef DECODE_WB_BYPASS_EN
    same_cycle_exp = 32'h1234_5678;
`else
    same_cycle_exp = 32'h0;
`endif
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234_5678;
    present(1'b1, 32'hC, 32'h0021_0233);
    tick();
    wb_we = 1'b0;
    check("bypass_rs1d", out_rs1_data, same_cycle_exp);

    // lw x5,0(x2) then add x6,x5,x5: one bubble
    present(1'b1, 32'h10, 32'h0001_2283);
    tick();
    check("lw_load", out_is_load, 1'b1);
    present(1'b1, 32'h14, 32'h0052_8333);
    #1 check("haz_ready", in_ready, 1'b0);
    tick();
    check("haz_bubble", out_valid, 1'b0);
    #1 check("haz_ready2", in_ready, 1'b1);
    tick();
    check("haz_issue_valid", out_valid, 1'b1);
    check("haz_issue_rd", out_rd, 5'd6);

    // stall three cycles with the next instruction waiting
    present(1'b1, 32'h18, 32'h0050_0093);
    tick();
    out_ready = 1'b0;
    present(1'b1, 32'h1C, 32'h0070_0113);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_imm", out_imm, 32'd5);
      check("stall_pc", out_pc, 32'h18);
    end
    out_ready = 1'b1;
    tick();
    check("release_imm", out_imm, 32'd7);
    check("release_pc", out_pc, 32'h1C);
    present(1'b0, 32'h20, 32'h0);
    tick();
    check("no_dup", out_valid, 1'b0);

    // flush kills the presented instruction
    present(1'b1, 32'h20, 32'h0050_0093);
    tick();
    flush = 1'b1;
    present(1'b1, 32'h24, 32'h0090_0393);
    tick();
    check("flush_valid", out_valid, 1'b0);
    flush = 1'b0;
    present(1'b0, 32'h28, 32'h0);
    tick();
    check("flush_gone", out_valid, 1'b0);

    // illegal word and negative branch offset
    present(1'b1, 32'h30, 32'hFFFF_FFFF);
    tick();
    check("ill_flag", out_illegal, 1'b1);
    check("ill_rw", out_reg_write, 1'b0);
    check("ill_valid", out_valid, 1'b1);
    present(1'b1, 32'h34, 32'hFE00_0EE3);
    tick();
    check("beq_imm", out_imm, 32'hFFFF_FFFC);

    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(99) != 0);
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(9) == 0);
      wb_we     = 1'($urandom_range(1));
      wb_rd     = 5'($urandom_range(5));
      wb_data   = $urandom;
      present(($urandom_range(3) != 0), $urandom, rand_instr());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 Parameter NREGS, default 32, register file depth; x0 is included.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous and active-low; sampled only on the rising clk edge.
REQ-005 Port in_valid  in  1  fetch is presenting an instruction.
REQ-006 Port in_ready  out  1  decode accepts the instruction this cycle.
REQ-007 Port in_pc  in  32  PC of the presented instruction.
REQ-008 Port in_instr  in  32  raw RV32I instruction word.
REQ-009 Port flush  in  1  branch/jump redirect; kill in-flight decode.
REQ-010 Port wb_we  in  1  register write enable from writeback.
REQ-011 Port wb_rd  in  5  writeback destination index.
REQ-012 Port wb_data  in  32  writeback data.
REQ-013 Port out_valid  out  1  decoded bundle is valid.
REQ-014 Port out_ready  in  1  execute accepts the bundle.
REQ-015 Port out_pc / out_rs1_data / out_rs2_data / out_imm  out  32 each  registered PC, operands and sign-extended immediate.
REQ-016 Port out_rd / out_rs1 / out_rs2  out  5 each  register indices.
REQ-017 Port out_opcode  out  7; out_funct3  out  3; out_funct7b5  out  1  decoded control fields.
REQ-018 Port out_is_load / out_reg_write / out_illegal  out  1 each  load flag, writes rd, unsupported opcode.

Function
REQ-019 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-020 in_ready SHALL be (!out_valid || out_ready) && !hazard && !flush.
REQ-021 The hazard signal SHALL be asserted when out_valid && out_is_load && out_rd!=0 && in_valid && the incoming rs1 or rs2 (by format) equals out_rd.
REQ-022 On a hazard with out_ready=1, the output register SHALL load a bubble (out_valid=0); the instruction is held and accepted on the next cycle.
REQ-023 On an input transfer, all out_* fields SHALL register next edge with 1-cycle latency, and out_valid=1.
REQ-024 With no input transfer and out_ready=1, out_valid SHALL drop to 0; with out_ready=0, all outputs SHALL hold stable.
REQ-025 flush=1 SHALL force out_valid=0 next edge, override an input transfer, and discard the presented instruction.
REQ-026 Immediates SHALL be decoded per RV32I I/S/B/U/J formats and sign-extended to 32 bits; R-type immediates SHALL be 0.
REQ-027 Opcodes outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM, FENCE} SHALL set out_illegal=1 and out_reg_write=0, with out_valid still asserted.
REQ-028 out_reg_write SHALL be 1 only for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd!=0.
REQ-029 The register file SHALL have 2 combinational read ports and 1 synchronous write port; writes to x0 are ignored, and x0 always reads 0.
REQ-030 A register write SHALL occur on every edge with wb_we=1, independent of stall or flush.

Reset
REQ-031 When rst_n=0 at an edge, out_valid SHALL be 0 and all other out_* SHALL be 0.
REQ-032 Reset SHALL clear all 32 registers to 0; a reset mid-stall drops the held instruction.
REQ-033 in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-034 Macro DECODE_WB_BYPASS_EN SHALL control read/write bypass.
REQ-035 With DECODE_WB_BYPASS_EN defined, a read of register r in the same cycle that wb_we=1 and wb_rd=r (r!=0) SHALL return wb_data.
REQ-036 Without DECODE_WB_BYPASS_EN, that read SHALL return the pre-write register value.

Verification
REQ-037 Reset, then present in_instr=0x00500093 (addi x1,x0,5), pc=0x0 -> next cycle out_valid=1, out_rd=1, out_imm=5, out_reg_write=1.
REQ-038 Write wb x1=0xDEADBEEF, then decode add x3,x1,x1 -> out_rs1_data=out_rs2_data=0xDEADBEEF; the same-cycle write matches the macro setting.
REQ-039 Decode lw x5,0(x2), then add x6,x5,x5 with out_ready=1 -> in_ready=0 for 1 cycle, a bubble out (out_valid=0), then the add issues.
REQ-040 out_ready=0 for 3 cycles with in_valid=1 -> all outputs stable, in_ready=0; release -> the next instruction follows with no loss or duplicate.
REQ-041 flush=1 while in_valid=1 and out_valid=1 -> next cycle out_valid=0, and the presented instruction is not decoded.
REQ-042 in_instr=0xFFFFFFFF -> out_illegal=1, out_reg_write=0; beq imm=-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC.
